// File: rtl/ap_itoff32_pkg.sv
// Shared F32 field constants and the converter state encoding.
// Also intended for the float-to-integer converter.
package ap_itoff32_pkg;

    localparam int F32_BIAS = 127;
    localparam int F32_MANT = 23;
    localparam int F32_EXP  = 8;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/ap_itoff32_rne_round24.sv
// Round-to-nearest-even increment of a 24-bit significand.
// Reports the carry out of the 24-bit field so the caller can bump the exponent.
module ap_rneRound24 (
    input  logic [23:0] sig,
    input  logic        guard,
    input  logic        sticky,
    output logic [22:0] frac,
    output logic        carry
);

    logic inc;

    assign inc   = guard & (sticky | sig[0]);
    // An all-ones significand wraps to zero fraction, which is exactly 1.0 after the carry.
    assign carry = (&sig) & inc;
    assign frac  = sig[22:0] + 23'(inc);

endmodule

// File: rtl/ap_itoff32.sv
// Signed integer to IEEE-754 single converter; normalises one bit per cycle,
// then rounds to nearest even in a single ROUND cycle.
module ap_itoff32
    import ap_itoff32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    output logic [31:0]      result,
    output logic             ready
);

    // Magnitude is widened on the right so guard/sticky always exist.
    localparam int MW = (WIDTH < 26) ? 26 : WIDTH;
    localparam logic [F32_EXP-1:0] EXP_INIT = F32_EXP'(F32_BIAS + WIDTH - 1);

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [F32_EXP-1:0] exp_q, exp_d;
    logic [31:0]        result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   a_mag;
    logic [MW-1:0]      ext;
    logic [23:0]        sig;
    logic               guard;
    logic               sticky;
    logic [F32_MANT-1:0] frac;
    logic               carry;

    assign a_mag  = a[WIDTH-1] ? ((~a) + WIDTH'(1)) : a;
    assign ext    = MW'(mag_q) << (MW - WIDTH);
    assign sig    = ext[MW-1 -: 24];
    assign guard  = ext[MW-25];
    assign sticky = |ext[MW-26:0];

    ap_rneRound24 u_round (
        .sig    (sig),
        .guard  (guard),
        .sticky (sticky),
        .frac   (frac),
        .carry  (carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        result_d = result_q;
        ready_d  = ready_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ready_d = 1'b0;
                    sign_d  = a[WIDTH-1];
                    mag_d   = a_mag;
                    exp_d   = EXP_INIT;
                    if (a == '0) begin
                        result_d = '0;
                        ready_d  = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d  = NORM;
                    end
                end
            end
            NORM: begin
                if (mag_q[WIDTH-1]) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - F32_EXP'(1);
                end
            end
            ROUND: begin
                result_d = {sign_q, exp_q + F32_EXP'(carry), frac};
                ready_d  = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_ap_itoff32.sv
// Directed plus random checks of ap_itoff32 (WIDTH=32) against an
// arithmetic int-to-float reference model.
module tb_ap_itoff32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;

    ap_itoff32 #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .result (result),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact magnitude, locate the leading one, divide down and round half-to-even.
    function automatic logic [31:0] ref_f32(input longint v);
        longint m, q, r, half, one;
        int p, e, sh;
        logic [63:0] qb;
        logic [31:0] eb;
        logic s;
        if (v == 0) return 32'h0;
        s = (v < 0);
        m = s ? -v : v;
        p = 0;
        for (int i = 0; i < 63; i++) if (((m >> i) & 64'd1) != 0) p = i;
        one = 1;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh = p - 23;
            q = m >> sh;
            r = m - (q << sh);
            half = one << (sh - 1);
            if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
        end
        e = 127 + p;
        if (q == (one << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        qb = q;
        eb = e;
        return {s, eb[7:0], qb[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] v);
        longint m;
        int p;
        if (v == 0) return 0;
        m = longint'($signed(v));
        if (m < 0) m = -m;
        p = 0;
        for (int i = 0; i < 63; i++) if (((m >> i) & 64'd1) != 0) p = i;
        return (31 - p) + 2;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Accepts val on one edge, then counts edges until ready (bounded).
    task automatic run(input logic [31:0] val, input string tag);
        int cyc;
        @(negedge clk);
        start = 1'b1;
        a = val;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (val != 0) check32({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        cyc = 0;
        while (!ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check32({tag, "_latency"}, cyc, ref_lat(val));
        check32({tag, "_result"}, result, ref_f32(longint'($signed(val))));
    endtask

    initial begin
        int cyc;
        logic seen;
        logic [31:0] v;
        rst = 1'b0;
        start = 1'b0;
        a = '0;
        #3;
        check32("reset_ready", {31'd0, ready}, 32'd0);
        check32("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run(32'd0, "zero");
        check32("zero_const", result, 32'h00000000);
        run(32'd1, "one");
        check32("one_const", result, 32'h3F800000);

        // Async reset in the middle of normalisation.
        @(negedge clk);
        start = 1'b1;
        a = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check32("midreset_ready", {31'd0, ready}, 32'd0);
        check32("midreset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check32("midreset_no_ready", {31'd0, seen}, 32'd0);

        run(32'hFFFFFFFF, "minus_one");
        check32("minus_one_const", result, 32'hBF800000);
        run(32'd16777217, "tie_even");
        check32("tie_even_const", result, 32'h4B800000);
        run(32'd16777219, "tie_up");
        check32("tie_up_const", result, 32'h4B800002);
        run(32'h7FFFFFFF, "max_pos");
        check32("max_pos_const", result, 32'h4F000000);
        run(32'h80000000, "min_neg");
        check32("min_neg_const", result, 32'hCF000000);

        // Second start during NORM must be ignored.
        @(negedge clk);
        start = 1'b1;
        a = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        start = 1'b1;
        a = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        while (!ready && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check32("ignored_latency", cyc, ref_lat(32'd5));
        check32("ignored_result", result, 32'h40A00000);

        // Restart in the first DONE cycle.
        run(32'hFFFFFFFD, "back2back");
        check32("back2back_const", result, 32'hC0400000);

        for (int i = 0; i < 40; i++) begin
            v = $urandom;
            v = $signed(v) >>> $urandom_range(0, 31);
            run(v, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
